// File: rtl/kb_pkg.sv
// kb_pkg: PS/2 scancode constants and the 32-entry key table with its lookup
package kb_pkg;
  localparam int NUM_KEYS = 32;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] KEY_CODES [NUM_KEYS] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
    8'h33, 8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26,
    8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C,
    8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h1C, 8'h2B, 8'h29
  };
  typedef struct packed {
    logic hit;
    logic [4:0] idx;
  } key_hit_t;
  // Scanning downward lets the lowest matching index win.
  function automatic key_hit_t key_index(input logic [7:0] code);
    key_hit_t r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (KEY_CODES[i] == code) begin
        r.hit = 1'b1;
        r.idx = 5'(i);
      end
    return r;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronizes PS/2 lines, deframes 11-bit frames, checks them, times out partial frames
module ps2_rx #(
  parameter int TIMEOUT_CYC = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [SYNC_STAGES-1:0] clk_s, dat_s;
  logic clk_prev, clk_q, dat_q, fall, frame_ok;
  logic [9:0] shift;
  logic [10:0] frame;
  logic [3:0] cnt;
  logic [TW-1:0] tcnt;
  always_comb begin
    clk_q = clk_s[SYNC_STAGES-1];
    dat_q = dat_s[SYNC_STAGES-1];
    fall = clk_prev & ~clk_q;
    frame = {dat_q, shift};
    frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s <= '1;
      dat_s <= '1;
      clk_prev <= 1'b1;
      shift <= '0;
      cnt <= '0;
      tcnt <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
    end else begin
      clk_s <= {clk_s[SYNC_STAGES-2:0], ps2_clk};
      dat_s <= {dat_s[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_q;
      rx_valid <= fall && cnt == 4'd10 && frame_ok;
      if (fall) begin
        rx_byte <= frame[8:1];
        shift <= {dat_q, shift[9:1]};
        cnt <= cnt == 4'd10 ? 4'd0 : cnt + 4'd1;
        tcnt <= '0;
      end else if (cnt != 4'd0) begin
        cnt <= tcnt == TW'(TIMEOUT_CYC - 1) ? 4'd0 : cnt;
        tcnt <= tcnt == TW'(TIMEOUT_CYC - 1) ? '0 : tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end
endmodule

// File: rtl/keyboard_decoder.sv
// keyboard_decoder: tracks break/extended prefixes and maintains the held-key bitmap
module keyboard_decoder
  import kb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk_100k,
  input  logic        i_rst_n,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [31:0] o_key
);
  logic [7:0] rx_byte;
  logic rx_valid, brk, ext;
  key_hit_t kh;
  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk(i_clk_100k),
    .rst(i_rst_n),
    .ps2_clk(PS2_CLK),
    .ps2_dat(PS2_DAT),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid)
  );
  always_comb kh = key_index(rx_byte);
  always_ff @(posedge i_clk_100k) begin
    if (i_rst_n) begin
      o_key <= '0;
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk <= 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext <= 1'b1;
      end else begin
        if (!ext && kh.hit) o_key[kh.idx] <= ~brk;
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_keyboard_decoder.sv
// tb_keyboard_decoder: directed PS/2 frame vectors plus timeout and mid-frame reset sequences
module tb_keyboard_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic [31:0] key;
  int checks = 0;
  int errors = 0;

  keyboard_decoder dut (
    .i_clk_100k(clk),
    .i_rst_n(rst),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .o_key(key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic bad_par;
    logic bad_stop;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [24];

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bp, input logic bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    checks++;
    if (key !== exp) begin
      errors++;
      $display("FAIL %s: o_key=%h expected %h", name, key, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{8'h1A, 1'b0, 1'b0, 32'h0000_0001};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 32'h0000_0001};
    tbl[2]  = '{8'h1A, 1'b0, 1'b0, 32'h0000_0000};
    tbl[3]  = '{8'h15, 1'b0, 1'b0, 32'h0000_1000};
    tbl[4]  = '{8'h29, 1'b0, 1'b0, 32'h8000_1000};
    tbl[5]  = '{8'h1A, 1'b0, 1'b0, 32'h8000_1001};
    tbl[6]  = '{8'hF0, 1'b0, 1'b0, 32'h8000_1001};
    tbl[7]  = '{8'h15, 1'b0, 1'b0, 32'h8000_0001};
    tbl[8]  = '{8'hF0, 1'b0, 1'b0, 32'h8000_0001};
    tbl[9]  = '{8'h1A, 1'b0, 1'b0, 32'h8000_0000};
    tbl[10] = '{8'hE0, 1'b0, 1'b0, 32'h8000_0000};
    tbl[11] = '{8'h1A, 1'b0, 1'b0, 32'h8000_0000};
    tbl[12] = '{8'h1A, 1'b0, 1'b0, 32'h8000_0001};
    tbl[13] = '{8'h22, 1'b1, 1'b0, 32'h8000_0001};
    tbl[14] = '{8'h22, 1'b0, 1'b1, 32'h8000_0001};
    tbl[15] = '{8'h22, 1'b0, 1'b0, 32'h8000_0005};
    tbl[16] = '{8'hF0, 1'b0, 1'b0, 32'h8000_0005};
    tbl[17] = '{8'h1A, 1'b1, 1'b0, 32'h8000_0005};
    tbl[18] = '{8'h1A, 1'b0, 1'b0, 32'h8000_0004};
    tbl[19] = '{8'h22, 1'b0, 1'b0, 32'h8000_0004};
    tbl[20] = '{8'hF0, 1'b0, 1'b0, 32'h8000_0004};
    tbl[21] = '{8'hAA, 1'b0, 1'b0, 32'h8000_0004};
    tbl[22] = '{8'h4D, 1'b0, 1'b0, 32'h9000_0004};
    tbl[23] = '{8'h2B, 1'b0, 1'b0, 32'hD000_0004};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset", 32'h0);
    repeat (1000) @(negedge clk);
    check("idle", 32'h0);

    for (int i = 0; i < 24; i++) begin
      send_bits(mk(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop), 11);
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d_%h", i, tbl[i].code), tbl[i].exp);
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset2", 32'h0);
    send_bits(mk(8'h1B, 1'b0, 1'b0), 5);
    repeat (250) @(negedge clk);
    check("partial", 32'h0);
    send_bits(mk(8'h22, 1'b0, 1'b0), 11);
    repeat (10) @(negedge clk);
    check("after_timeout", 32'h0000_0004);

    send_bits(mk(8'h1B, 1'b0, 1'b0), 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset", 32'h0);
    send_bits(mk(8'h1B, 1'b0, 1'b0), 11);
    repeat (10) @(negedge clk);
    check("after_reset", 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
